// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

  // Word-address and data widths of the fetch read port
  localparam int IMEM_AW = 30;
  localparam int IMEM_DW = 32;

  // Word returned when fetch addresses beyond the populated array
  localparam logic [IMEM_DW-1:0] IMEM_OOR_WORD = 32'h0000_0000;

  // Loader session states
  typedef enum logic [1:0] {
    IMEM_LD_IDLE    = 2'd0,
    IMEM_LD_COLLECT = 2'd1,
    IMEM_LD_COMMIT  = 2'd2
  } imem_ld_state_e;

endpackage

// File: rtl/imem_ld_assembler.sv
// rtl/imem_ld_assembler.sv - little-endian byte lane assembler for the boot loader port
module imem_ld_assembler
  import imem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  input  logic               last_i,
  output logic               word_valid_o,
  output logic [IMEM_DW-1:0] word_data_o
);

  logic [1:0]         byte_idx;
  logic [IMEM_DW-1:0] lanes;

  // Drop each accepted byte into its lane; clear restarts a word with empty lanes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx <= 2'd0;
      lanes    <= '0;
    end else if (clear_i) begin
      byte_idx <= 2'd0;
      lanes    <= '0;
    end else if (byte_valid_i) begin
      lanes[{byte_idx, 3'b000} +: 8] <= byte_data_i;
      byte_idx                       <= byte_idx + 2'd1;
    end
  end

  // A word is complete on its 4th byte or on an early last byte; lanes hold it next cycle
  assign word_valid_o = byte_valid_i & ((byte_idx == 2'd3) | last_i);
  assign word_data_o  = lanes;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-port instruction memory with byte-serial boot loader; option IMEM_WRITE_BYPASS_EN
module imem_responder
  import imem_pkg::*;
#(
  parameter int                 DEPTH    = 1024,
  parameter logic [IMEM_DW-1:0] OOR_WORD = IMEM_OOR_WORD
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               re_i,
  input  logic [IMEM_AW-1:0] rmemaddr_i,
  output logic [IMEM_DW-1:0] rmemdata_o,
  output logic               fault_o,
  input  logic               ld_start_i,
  input  logic [IMEM_AW-1:0] ld_addr_i,
  input  logic               ld_valid_i,
  input  logic [7:0]         ld_data_i,
  input  logic               ld_last_i,
  output logic               ld_ready_o,
  output logic               ld_busy_o,
  output logic [15:0]        ld_count_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [IMEM_DW-1:0] mem [DEPTH];

  imem_ld_state_e     state, state_nxt;
  logic [AW-1:0]      waddr;
  logic               last_seen;
  logic               fire, start_ok, commit;
  logic               asm_clear, word_valid;
  logic [IMEM_DW-1:0] word_data;
  logic [AW-1:0]      rd_idx;
  logic               rd_in_range;
  logic [IMEM_DW-1:0] rd_word;
  logic               ld_addr_unused;

  // Start addresses are taken modulo DEPTH, so the high bits never matter
  assign ld_addr_unused = ^(ld_addr_i >> AW);

  assign fire      = ld_valid_i & ld_ready_o;
  assign start_ok  = (state == IMEM_LD_IDLE) & ld_start_i;
  assign commit    = (state == IMEM_LD_COMMIT);
  assign asm_clear = start_ok | commit;

  imem_ld_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (asm_clear),
    .byte_valid_i (fire),
    .byte_data_i  (ld_data_i),
    .last_i       (ld_last_i),
    .word_valid_o (word_valid),
    .word_data_o  (word_data)
  );

  // Loader state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IMEM_LD_IDLE;
    else         state <= state_nxt;
  end

  // Loader next-state: collect until a word completes, commit for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IMEM_LD_IDLE:    if (ld_start_i) state_nxt = IMEM_LD_COLLECT;
      IMEM_LD_COLLECT: if (fire && word_valid) state_nxt = IMEM_LD_COMMIT;
      IMEM_LD_COMMIT:  state_nxt = last_seen ? IMEM_LD_IDLE : IMEM_LD_COLLECT;
      default:         state_nxt = IMEM_LD_IDLE;
    endcase
  end

  // Loader outputs: bytes are accepted only while collecting
  always_comb begin
    ld_ready_o = 1'b0;
    ld_busy_o  = 1'b0;
    if (state == IMEM_LD_COLLECT) ld_ready_o = 1'b1;
    if (state != IMEM_LD_IDLE)    ld_busy_o  = 1'b1;
  end

  // Session bookkeeping: write pointer, committed-word count, end-of-session flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr      <= '0;
      ld_count_o <= '0;
      last_seen  <= 1'b0;
    end else begin
      if (start_ok) begin
        waddr      <= ld_addr_i[AW-1:0];
        ld_count_o <= '0;
        last_seen  <= 1'b0;
      end else if (commit) begin
        waddr <= waddr + 1'b1;
        if (ld_count_o != 16'hFFFF) ld_count_o <= ld_count_o + 16'd1;
      end
      if (fire && word_valid) last_seen <= ld_last_i;
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (commit) mem[waddr] <= word_data;
  end

  assign rd_idx      = rmemaddr_i[AW-1:0];
  assign rd_in_range = ({2'b00, rmemaddr_i} < DEPTH_W);

  // Same-address read during a commit: forward the new word or return the old one
  always_comb begin
`ifdef IMEM_WRITE_BYPASS_EN
    rd_word = (commit && (rd_idx == waddr)) ? word_data : mem[rd_idx];
`else
    rd_word = mem[rd_idx];
`endif
  end

  // Fetch read register; holds while re_i is low, fault is sticky until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rmemdata_o <= '0;
      fault_o    <= 1'b0;
    end else if (re_i) begin
      if (rd_in_range) begin
        rmemdata_o <= rd_word;
      end else begin
        rmemdata_o <= OOR_WORD;
        fault_o    <= 1'b1;
      end
    end
  end

endmodule
